// File: rtl/sbox_ti_host_pkg.sv
// rtl/sbox_ti_host_pkg.sv - shared FSM states, LFSR constants and share counts for the TI S-box host
package sbox_ti_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_LOAD,
    ST_WAIT_RDY,
    ST_SKIP,
    ST_CAP,
    ST_DONE
  } state_t;

  localparam int LFSR_W = 32;
  // Right-shifting Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam int SHARE_CNT  = 3;
  localparam int LOAD_BYTES = 5;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/sbox_ti_host_lfsr.sv
// rtl/sbox_ti_host_lfsr.sv - free-running seeded 32-bit Galois LFSR supplying mask and refresh bytes
module sbox_ti_host_lfsr
  import sbox_ti_host_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h1ACE_B00C
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [LFSR_W-1:0] o_state
);

  // An all-zero state would lock the register up, so it is swapped for 1
  localparam logic [LFSR_W-1:0] SEED_OK = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED_OK;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/sbox_ti_host.sv
// rtl/sbox_ti_host.sv - masks a plain byte into three shares, drives the TI S-box core, recombines the result
module sbox_ti_host
  import sbox_ti_host_pkg::*;
#(
  parameter logic [31:0] SEED        = 32'h1ACE_B00C,
  parameter int          RDY_TO_DATA = 2,
  parameter int          TIMEOUT     = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_data,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic       o_core_rst,
  output logic       o_core_load,
  output logic [7:0] o_core_data,
  input  logic       i_core_ready,
  input  logic [7:0] i_core_q
);

  localparam int CNT_W  = $clog2(TIMEOUT + LOAD_BYTES + 1);
  localparam int LOAD_W = 8 * LOAD_BYTES;
  localparam logic [CNT_W-1:0] C_LOAD_LAST = CNT_W'(LOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_SKIP_LAST = CNT_W'((RDY_TO_DATA > 1) ? RDY_TO_DATA - 2 : 0);
  localparam logic [CNT_W-1:0] C_CAP_LAST  = CNT_W'(SHARE_CNT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [LOAD_W-1:0] r_load;
  logic [7:0]        r_acc;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_err;
  logic              w_timeout;
  logic [LFSR_W-1:0] w_lfsr;
  logic [7:0]        w_s1;
  logic [7:0]        w_s2;

  sbox_ti_host_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_state(w_lfsr)
  );

  assign w_s1 = w_lfsr[31:24];
  assign w_s2 = w_lfsr[23:16];

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_core_load = 1'b0;
    o_core_data = 8'h00;
    o_core_rst  = i_rst;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = !i_rst;
        if (i_req_valid) w_next = ST_CRST;
      end
      ST_CRST: begin
        o_core_rst = 1'b1;
        w_next     = ST_LOAD;
      end
      ST_LOAD: begin
        o_core_load = !i_rst;
        o_core_data = i_rst ? 8'h00 : r_load[LOAD_W-1 -: 8];
        if (r_cnt == C_LOAD_LAST) w_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        // A ready seen in the very cycle the budget runs out still wins
        if (i_core_ready) begin
          if (RDY_TO_DATA > 1) w_next = ST_SKIP;
          else                 w_next = ST_CAP;
        end else if (r_cnt == C_TIMEOUT) begin
          w_next    = ST_DONE;
          w_timeout = 1'b1;
        end
      end
      ST_SKIP: begin
        if (r_cnt == C_SKIP_LAST) w_next = ST_CAP;
      end
      ST_CAP: begin
        if (r_cnt == C_CAP_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_rsp_valid = !i_rst;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_load     <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      // Shares go out MSB-first: s1, s2, s3, r0, r1
      if (r_state == ST_IDLE && i_req_valid) begin
        r_load <= {w_s1, w_s2, i_req_data ^ w_s1 ^ w_s2, w_lfsr[15:0]};
        r_acc  <= '0;
      end else if (r_state == ST_LOAD) begin
        r_load <= {r_load[LOAD_W-9:0], 8'h00};
      end
      if (r_state == ST_CAP) r_acc <= r_acc ^ i_core_q;
      if (w_next == ST_DONE) begin
        r_rsp_err  <= w_timeout;
        r_rsp_data <= w_timeout ? 8'h00 : (r_acc ^ i_core_q);
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_sbox_ti_host.sv
// tb/tb_sbox_ti_host.sv - self-checking bench for sbox_ti_host against a behavioural TI core and AES S-box table
module tb_sbox_ti_host;

  localparam logic [31:0] SEED    = 32'h1ACE_B00C;
  localparam int          TIMEOUT = 32;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req_valid = 1'b0;
  logic [7:0] i_req_data = 8'h00;
  logic       i_core_ready = 1'b0;
  logic [7:0] i_core_q = 8'h00;
  logic       o_req_ready;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_data;
  logic       o_rsp_err;
  logic       o_core_rst;
  logic       o_core_load;
  logic [7:0] o_core_data;

  always #5 i_clk = ~i_clk;

  sbox_ti_host #(
    .SEED       (SEED),
    .RDY_TO_DATA(2),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_data  (i_req_data),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_core_rst  (o_core_rst),
    .o_core_load (o_core_load),
    .o_core_data (o_core_data),
    .i_core_ready(i_core_ready),
    .i_core_q    (i_core_q)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] ref_lfsr = SEED;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8 * int'(x) -: 8];
  endfunction

  // Divide-by-x step of the feedback polynomial x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural core: takes 5 load bytes, raises ready 2 cycles after load drops,
  // shows q1,q2,q3 two cycles after ready; random garbage on q otherwise.
  bit         cm_dead = 1'b0;
  int         cm_n = 0;
  int         cm_t = -1;
  logic [7:0] cm_b [5];
  logic [7:0] cm_q1 = 8'h00;
  logic [7:0] cm_q2 = 8'h00;
  logic [7:0] cm_q3 = 8'h00;

  always @(posedge i_clk) begin
    cyc++;
    ref_lfsr = i_rst ? SEED : lfsr_step(ref_lfsr);
    if (o_core_rst) begin
      cm_n = 0;
      cm_t = -1;
      i_core_ready <= 1'b0;
    end else begin
      if (o_core_load) begin
        if (cm_n < 5) cm_b[cm_n] = o_core_data;
        cm_n++;
        cm_t = 0;
        if (cm_n == 5) begin
          cm_q1 = 8'($urandom);
          cm_q2 = 8'($urandom);
          cm_q3 = sbox(cm_b[0] ^ cm_b[1] ^ cm_b[2]) ^ cm_q1 ^ cm_q2;
        end
      end else if (cm_t >= 0) begin
        cm_t++;
      end
      if (cm_t == 2 && !cm_dead) i_core_ready <= 1'b1;
    end
    case (cm_t)
      4:       i_core_q <= cm_q1;
      5:       i_core_q <= cm_q2;
      6:       i_core_q <= cm_q3;
      default: i_core_q <= 8'($urandom);
    endcase
  end

  // Issues one request (caller sits just after a falling edge) and checks the whole op
  task automatic run_op(input logic [7:0] x, input bit hold, input bit dead,
                        input int exp_lat, input logic [7:0] exp_data, input bit exp_err,
                        output int acc_cyc, output logic [39:0] loaded);
    int          lat, wait_n, n_ld, n_rst, rst_k, extra, bad_data;
    logic [31:0] snap;
    logic [7:0]  data;
    logic        err;
    cm_dead     = dead;
    i_req_data  = x;
    i_req_valid = 1'b1;
    wait_n = 0;
    while (!o_req_ready && wait_n < 100) begin
      @(negedge i_clk);
      wait_n++;
    end
    check("accept_wait", 64'(o_req_ready), 64'd1);
    acc_cyc = cyc;
    snap    = ref_lfsr;
    lat = -1; n_ld = 0; n_rst = 0; rst_k = -1; extra = 0; bad_data = 0;
    loaded = '0; data = 8'h00; err = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge i_clk);
      i_req_valid = hold;
      if (o_core_load) begin
        loaded = {loaded[31:0], o_core_data};
        n_ld++;
      end else if (o_core_data != 8'h00) begin
        bad_data++;
      end
      if (o_core_rst) begin
        n_rst++;
        rst_k = k;
      end
      if (i_req_valid && o_req_ready) extra++;
      if (o_rsp_valid) begin
        lat  = k;
        data = o_rsp_data;
        err  = o_rsp_err;
      end
    end
    i_req_valid = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_data", 64'(data), 64'(exp_data));
    check("rsp_err", 64'(err), 64'(exp_err));
    check("load_count", 64'(n_ld), 64'd5);
    check("load_bytes", 64'(loaded), 64'({snap[31:16], x ^ snap[31:24] ^ snap[23:16], snap[15:0]}));
    check("share_xor", 64'(loaded[39:32] ^ loaded[31:24] ^ loaded[23:16]), 64'(x));
    check("core_rst_count", 64'(n_rst), 64'd1);
    check("core_rst_cycle", 64'(rst_k), 64'd1);
    check("core_data_idle", 64'(bad_data), 64'd0);
    if (hold) check("single_accept", 64'(extra), 64'd0);
    @(negedge i_clk);
    check("rsp_pulse", 64'(o_rsp_valid), 64'd0);
    check("ready_after", 64'(o_req_ready), 64'd1);
    check("rsp_hold", 64'(o_rsp_data), 64'(exp_data));
  endtask

  typedef struct {
    logic [7:0] x;
    bit         hold;
    bit         dead;
    int         lat;
    logic [7:0] data;
    bit         err;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  order [256];
  int          acc, prev_acc, prev_lat;
  logic [39:0] loaded;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 1'b0, 14, 8'h63, 1'b0};
    vecs[1] = '{8'h53, 1'b0, 1'b0, 14, 8'hED, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 14, 8'h16, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 7 + TIMEOUT + 1, 8'h00, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 14, 8'h7C, 1'b0};
    vecs[5] = '{8'h10, 1'b1, 1'b0, 14, 8'hCA, 1'b0};

    repeat (3) @(negedge i_clk);
    check("rst_req_ready", 64'(o_req_ready), 64'd0);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(o_rsp_data), 64'd0);
    check("rst_rsp_err", 64'(o_rsp_err), 64'd0);
    check("rst_core_load", 64'(o_core_load), 64'd0);
    check("rst_core_data", 64'(o_core_data), 64'd0);
    check("rst_core_rst", 64'(o_core_rst), 64'd1);
    i_rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(o_req_ready), 64'd1);
    check("post_rst_core_rst", 64'(o_core_rst), 64'd0);

    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, vecs[i].hold, vecs[i].dead, vecs[i].lat, vecs[i].data, vecs[i].err,
             acc, loaded);
      if (i > 0) check("accept_gap", 64'(acc - prev_acc), 64'(prev_lat + 1));
      prev_acc = acc;
      prev_lat = vecs[i].lat;
    end

    // Reset in cycle 8 of an op: abort silently, LFSR back at SEED
    i_req_data  = 8'h53;
    i_req_valid = 1'b1;
    check("abort_accept_ready", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (7) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("abort_req_ready_low", 64'(o_req_ready), 64'd0);
    check("abort_core_rst", 64'(o_core_rst), 64'd1);
    check("abort_no_rsp", 64'(o_rsp_valid), 64'd0);
    @(negedge i_clk);
    check("abort_core_load", 64'(o_core_load), 64'd0);
    check("abort_no_rsp2", 64'(o_rsp_valid), 64'd0);
    i_rst = 1'b0;
    #1;
    check("abort_ready_after", 64'(o_req_ready), 64'd1);
    run_op(8'h01, 1'b0, 1'b0, 14, 8'h7C, 1'b0, acc, loaded);
    check("seed_after_reset", 64'(loaded), 64'h1A_CE_D5_B0_0C);

    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int         j;
      logic [7:0] t;
      j        = int'($urandom_range(i, 0));
      t        = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge i_clk);
      run_op(order[i], 1'($urandom_range(1, 0)), 1'b0, 14, sbox(order[i]), 1'b0, acc, loaded);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sbox_ti_host.md
# sbox_ti_host

Host-side driver for the byte-serial three-share threshold-implementation AES S-box core. It accepts one plain byte per request and splits it into three Boolean shares using an internal LFSR. It streams the shares and two fresh randomness bytes into the core over the core's load/data port, then collects the three returned output shares after the core raises ready. It XOR-recombines them and presents the unmasked S-box byte with a one-cycle valid.

## Interface
- SEED, 32'h1ACE_B00C: LFSR reset value; 0 is illegal and is replaced by 32'h1.
- RDY_TO_DATA, 2: cycles from first observed core_ready high to first output-share sample.
- TIMEOUT, 32: maximum cycles waited for core_ready.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_data  in  8  plain input byte x.
- rsp_valid  out  1  one-cycle pulse; rsp_data/rsp_err valid.
- rsp_data  out  8  recombined result q1^q2^q3; holds until next rsp_valid.
- rsp_err  out  1  set with rsp_valid on timeout.
- core_rst  out  1  core reset: rst OR state CRST.
- core_load  out  1  core load strobe.
- core_data  out  8  byte into core shift register.
- core_ready  in  1  core output-ready flag.
- core_q  in  8  core output byte bus.

## Operation
- 32-bit Galois LFSR (taps 32,22,2,1), free-running one step/cycle; never stalls.
- On req_valid & req_ready: latch x, snapshot LFSR → m1=[31:24], m2=[23:16], r0=[15:8], r1=[7:0].
- Shares: s1=m1, s2=m2, s3=x^m1^m2.
- FSM states:
  - IDLE: req_ready=1; accept → CRST.
  - CRST: 1 cycle, core_rst=1 → LOAD.
  - LOAD: 5 cycles, core_load=1, core_data=s1,s2,s3,r0,r1 in that order; idx 0..4 → WAIT_RDY.
  - WAIT_RDY: core_load=0, core_data=0. Timeout counter increments each cycle. On core_ready=1 → SKIP. Counter reaching TIMEOUT → DONE with err=1.
  - SKIP: RDY_TO_DATA−1 cycles → CAP; RDY_TO_DATA=1 goes straight to CAP.
  - CAP: 3 cycles, acc ^= core_q each cycle (acc cleared on accept) → DONE.
  - DONE: 1 cycle, rsp_valid=1, rsp_data=acc (or 0 on err), rsp_err=err → IDLE.
- One request in flight; req_valid outside IDLE is ignored (no queueing).
- core_ready is never sampled outside WAIT_RDY; stale ready from a previous op is cleared by CRST.

## Timing
- Reset values: state IDLE, req_ready=1 after the reset edge (0 while rst high), rsp_valid=0, rsp_data=0, rsp_err=0, core_load=0, core_data=0, core_rst=1 while rst, LFSR=SEED.
- Accept edge = E0. CRST is cycle 1. LOAD is cycles 2–6. WAIT_RDY starts at cycle 7.
- Conforming core raises ready 2 cycles after load falls, so ready is seen in cycle 9. Samples are taken in cycles 11, 12, 13. rsp_valid is asserted in cycle 14. Next accept is possible in cycle 15.
- Timeout: rsp_valid in cycle 7+TIMEOUT+1 with rsp_err=1.
- rst mid-operation: abort immediately, return to IDLE, no rsp_valid; core_rst asserted during rst.

## Structure
- Shared package: state enum, LFSR taps/width, SHARE_CNT=3, LOAD_BYTES=5.
- One sub-module: sbox_ti_host_lfsr (32-bit Galois, seeded, free-running).
- Bench uses a cycle-accurate behavioural core model plus a reference AES S-box table.

## Test plan
- x=0x00, conforming core model → rsp_valid cycle 14, rsp_data=0x63, rsp_err=0.
- x=0x53 then x=0xFF back-to-back → 0xED then 0x16. Second accept occurs in cycle 15 after the first, and core_rst pulses before each op.
- Load capture: monitor core_data during LOAD → s1^s2^s3 == x, bytes match the LFSR snapshot, exactly 5 core_load cycles.
- core_ready tied 0, x=0x01 → rsp_valid at cycle 7+TIMEOUT+1, rsp_err=1, rsp_data=0x00; next request x=0x01 with a good core → 0x7C.
- rst asserted in cycle 8 of an op → no rsp_valid, req_ready=1 after the reset edge, LFSR=SEED.
- req_valid held high during busy states → only one accept per op; all 256 x values give rsp_data = S-box(x).
